// File: rtl/me_feeder_pkg.sv
// Shared constants, state encoding and address helper for the motion-estimation data feeder.
package me_feeder_pkg;

  localparam int PIX_W          = 8;
  localparam int ROW_PIX        = 32;
  localparam int ROW_W          = PIX_W * ROW_PIX;
  localparam int CURR_AW        = 6;
  localparam int REF_AW         = 12;
  localparam int CURR_BURST_MAX = 32;
  localparam int IDLE_TIMEOUT   = 64;

  localparam logic CB12 = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } feeder_state_e;

  // Sub-block pair 1/2 lives in the lower half of the current-block memory.
  function automatic logic [CURR_AW-1:0] curr_addr(input logic cb_select, input logic [4:0] row);
    return {(cb_select != CB12), row};
  endfunction

endpackage

// File: rtl/me_rd_pipe.sv
// Two-stage read pipeline: registered request/address, then registered row data with tag and valid.
module me_rd_pipe
  import me_feeder_pkg::*;
#(
  parameter int AW    = 6,
  parameter int TAG_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [AW-1:0]    req_addr,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [ROW_W-1:0] rd_data,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr,
  output logic [ROW_W-1:0] row,
  output logic             row_valid,
  output logic [TAG_W-1:0] row_tag
);

  logic             rd_en_q, rd_en_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [TAG_W-1:0] tag_s1_q, tag_s1_d;
  logic             pend_q, pend_d;
  logic [TAG_W-1:0] tag_s2_q, tag_s2_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             row_valid_q, row_valid_d;
  logic [TAG_W-1:0] row_tag_q, row_tag_d;

  // The tag waits one extra stage so it meets the memory data, which lags rd_en by a cycle.
  always_comb begin
    rd_en_d     = req;
    rd_addr_d   = rd_addr_q;
    tag_s1_d    = tag_s1_q;
    pend_d      = rd_en_q;
    tag_s2_d    = tag_s2_q;
    row_d       = row_q;
    row_valid_d = pend_q;
    row_tag_d   = row_tag_q;
    if (req) begin
      rd_addr_d = req_addr;
      tag_s1_d  = req_tag;
    end
    if (rd_en_q) tag_s2_d = tag_s1_q;
    if (pend_q) begin
      row_d     = rd_data;
      row_tag_d = tag_s2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      tag_s1_q    <= '0;
      pend_q      <= 1'b0;
      tag_s2_q    <= '0;
      row_q       <= '0;
      row_valid_q <= 1'b0;
      row_tag_q   <= '0;
    end else begin
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      tag_s1_q    <= tag_s1_d;
      pend_q      <= pend_d;
      tag_s2_q    <= tag_s2_d;
      row_q       <= row_d;
      row_valid_q <= row_valid_d;
      row_tag_q   <= row_tag_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign row       = row_q;
  assign row_valid = row_valid_q;
  assign row_tag   = row_tag_q;

endmodule

// File: rtl/me_data_feeder.sv
// Memory-side responder to the PE array controller: turns request strobes into memory reads and tagged rows.
// Optional issued-read statistics are built when ME_FEEDER_STATS_EN is defined.
module me_data_feeder
  import me_feeder_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_curr_enable,
  input  logic               CB_select,
  input  logic               change_ref,
  input  logic               ref_input_control,
  input  logic [4:0]         search_column_count,
  input  logic [6:0]         search_row_count,
  output logic               curr_rd_en,
  output logic [CURR_AW-1:0] curr_rd_addr,
  input  logic [ROW_W-1:0]   curr_rd_data,
  output logic               ref_rd_en,
  output logic [REF_AW-1:0]  ref_rd_addr,
  input  logic [ROW_W-1:0]   ref_rd_data,
  output logic [ROW_W-1:0]   curr_row,
  output logic               curr_row_valid,
  output logic               curr_row_cb,
  output logic [4:0]         curr_row_idx,
  output logic [ROW_W-1:0]   ref_row,
  output logic               ref_row_valid,
  output logic [15:0]        stat_curr_cnt,
  output logic [15:0]        stat_ref_cnt
);

  feeder_state_e state_q, state_d;
  logic [6:0]    idle_cnt_q, idle_cnt_d;
  logic          prev_cb_q, prev_cb_d;
  logic [5:0]    burst_cnt_q, burst_cnt_d;
  logic [4:0]    curr_ptr_q, curr_ptr_d;
  logic [6:0]    ref_ptr_q, ref_ptr_d;

  logic        restart, curr_req, ref_req;
  logic [4:0]  eff_ptr;
  logic [5:0]  eff_cnt;
  logic [6:0]  ref_row_sel;
  logic [5:0]  curr_tag;
  logic        ref_tag_unused;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ST_IDLE: begin
        idle_cnt_d = '0;
        if (in_curr_enable) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (in_curr_enable || change_ref) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == 7'(IDLE_TIMEOUT - 1)) begin
          state_d    = ST_IDLE;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 7'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A dropped enable or a sub-block switch restarts the burst at row 0 in the same cycle.
  always_comb begin
    restart     = !in_curr_enable || (CB_select != prev_cb_q);
    eff_ptr     = restart ? 5'd0 : curr_ptr_q;
    eff_cnt     = restart ? 6'd0 : burst_cnt_q;
    curr_req    = in_curr_enable && (eff_cnt < 6'(CURR_BURST_MAX));
    curr_ptr_d  = eff_ptr;
    burst_cnt_d = eff_cnt;
    prev_cb_d   = CB_select;
    if (curr_req) begin
      curr_ptr_d  = eff_ptr + 5'd1;
      burst_cnt_d = eff_cnt + 6'd1;
    end

    ref_req     = (state_q == ST_ACTIVE) && change_ref && ref_input_control;
    ref_row_sel = (search_row_count == 7'd0) ? 7'd0 : ref_ptr_q;
    ref_ptr_d   = ref_ptr_q;
    if (state_d == ST_IDLE) ref_ptr_d = '0;
    else if (ref_req)       ref_ptr_d = ref_row_sel + 7'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_cb_q   <= 1'b0;
      burst_cnt_q <= '0;
      curr_ptr_q  <= '0;
      ref_ptr_q   <= '0;
    end else begin
      prev_cb_q   <= prev_cb_d;
      burst_cnt_q <= burst_cnt_d;
      curr_ptr_q  <= curr_ptr_d;
      ref_ptr_q   <= ref_ptr_d;
    end
  end

  me_rd_pipe #(.AW(CURR_AW), .TAG_W(6)) u_curr_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (curr_req),
    .req_addr  (curr_addr(CB_select, eff_ptr)),
    .req_tag   ({CB_select, eff_ptr}),
    .rd_data   (curr_rd_data),
    .rd_en     (curr_rd_en),
    .rd_addr   (curr_rd_addr),
    .row       (curr_row),
    .row_valid (curr_row_valid),
    .row_tag   (curr_tag)
  );

  assign {curr_row_cb, curr_row_idx} = curr_tag;

  me_rd_pipe #(.AW(REF_AW), .TAG_W(1)) u_ref_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (ref_req),
    .req_addr  ({search_column_count, ref_row_sel}),
    .req_tag   (1'b0),
    .rd_data   (ref_rd_data),
    .rd_en     (ref_rd_en),
    .rd_addr   (ref_rd_addr),
    .row       (ref_row),
    .row_valid (ref_row_valid),
    .row_tag   (ref_tag_unused)
  );

`ifdef ME_FEEDER_STATS_EN
  logic [15:0] stat_curr_cnt_q, stat_curr_cnt_d;
  logic [15:0] stat_ref_cnt_q, stat_ref_cnt_d;

  always_comb begin
    stat_curr_cnt_d = stat_curr_cnt_q;
    stat_ref_cnt_d  = stat_ref_cnt_q;
    if (curr_req && stat_curr_cnt_q != 16'hFFFF) stat_curr_cnt_d = stat_curr_cnt_q + 16'd1;
    if (ref_req && stat_ref_cnt_q != 16'hFFFF)   stat_ref_cnt_d  = stat_ref_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_curr_cnt_q <= '0;
      stat_ref_cnt_q  <= '0;
    end else begin
      stat_curr_cnt_q <= stat_curr_cnt_d;
      stat_ref_cnt_q  <= stat_ref_cnt_d;
    end
  end

  assign stat_curr_cnt = stat_curr_cnt_q;
  assign stat_ref_cnt  = stat_ref_cnt_q;
`else
  assign stat_curr_cnt = 16'd0;
  assign stat_ref_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_me_data_feeder.sv
// Scoreboard bench for me_data_feeder: directed request vectors push expected reads/rows, a negedge monitor checks them.
module tb_me_data_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_curr_enable, CB_select, change_ref, ref_input_control;
  logic [4:0]   search_column_count;
  logic [6:0]   search_row_count;
  logic         curr_rd_en, ref_rd_en;
  logic [5:0]   curr_rd_addr;
  logic [11:0]  ref_rd_addr;
  logic [255:0] curr_rd_data = '0;
  logic [255:0] ref_rd_data  = '0;
  logic [255:0] curr_row, ref_row;
  logic         curr_row_valid, curr_row_cb, ref_row_valid;
  logic [4:0]   curr_row_idx;
  logic [15:0]  stat_curr_cnt, stat_ref_cnt;

  typedef struct {
    logic [11:0] addr;
    int          cyc;
  } rd_exp_t;

  typedef struct {
    logic [255:0] data;
    logic         cb;
    logic [4:0]   idx;
    int           cyc;
  } row_exp_t;

  rd_exp_t  curr_rd_q[$];
  rd_exp_t  ref_rd_q[$];
  row_exp_t curr_row_q[$];
  row_exp_t ref_row_q[$];

  int cyc     = 0;
  int n_check = 0;
  int n_fail  = 0;
  int n_curr  = 0;
  int n_ref   = 0;

  me_data_feeder dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_curr_enable      (in_curr_enable),
    .CB_select           (CB_select),
    .change_ref          (change_ref),
    .ref_input_control   (ref_input_control),
    .search_column_count (search_column_count),
    .search_row_count    (search_row_count),
    .curr_rd_en          (curr_rd_en),
    .curr_rd_addr        (curr_rd_addr),
    .curr_rd_data        (curr_rd_data),
    .ref_rd_en           (ref_rd_en),
    .ref_rd_addr         (ref_rd_addr),
    .ref_rd_data         (ref_rd_data),
    .curr_row            (curr_row),
    .curr_row_valid      (curr_row_valid),
    .curr_row_cb         (curr_row_cb),
    .curr_row_idx        (curr_row_idx),
    .ref_row             (ref_row),
    .ref_row_valid       (ref_row_valid),
    .stat_curr_cnt       (stat_curr_cnt),
    .stat_ref_cnt        (stat_ref_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] curr_pat(input logic [5:0] a);
    return {32{2'b10, a}};
  endfunction

  function automatic logic [255:0] ref_pat(input logic [11:0] a);
    return {16{4'hC, a}};
  endfunction

  // Memories answer one cycle after the read strobe.
  always @(posedge clk) begin
    if (curr_rd_en) curr_rd_data <= curr_pat(curr_rd_addr);
    if (ref_rd_en)  ref_rd_data  <= ref_pat(ref_rd_addr);
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_check++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic cb, input logic chg, input logic ctl,
                               input logic [4:0] col, input logic [6:0] row,
                               input logic exp_c, input logic [5:0] ca,
                               input logic exp_r, input logic [11:0] ra);
    rd_exp_t  r;
    row_exp_t w;
    in_curr_enable      = en;
    CB_select           = cb;
    change_ref          = chg;
    ref_input_control   = ctl;
    search_column_count = col;
    search_row_count    = row;
    if (exp_c) begin
      r.addr = {6'd0, ca};
      r.cyc  = cyc + 1;
      curr_rd_q.push_back(r);
      w.data = curr_pat(ca);
      w.cb   = ~ca[5];
      w.idx  = ca[4:0];
      w.cyc  = cyc + 3;
      curr_row_q.push_back(w);
      n_curr++;
    end
    if (exp_r) begin
      r.addr = ra;
      r.cyc  = cyc + 1;
      ref_rd_q.push_back(r);
      w.data = ref_pat(ra);
      w.cb   = 1'b0;
      w.idx  = 5'd0;
      w.cyc  = cyc + 3;
      ref_row_q.push_back(w);
      n_ref++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 5'd0, 7'd0, 0, 6'd0, 0, 12'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_curr_rd_en"},     curr_rd_en, 0);
    checkOutput({tag, "_curr_rd_addr"},   curr_rd_addr, 0);
    checkOutput({tag, "_ref_rd_en"},      ref_rd_en, 0);
    checkOutput({tag, "_ref_rd_addr"},    ref_rd_addr, 0);
    checkOutput({tag, "_curr_row"},       curr_row, 0);
    checkOutput({tag, "_curr_row_valid"}, curr_row_valid, 0);
    checkOutput({tag, "_curr_row_cb"},    curr_row_cb, 0);
    checkOutput({tag, "_curr_row_idx"},   curr_row_idx, 0);
    checkOutput({tag, "_ref_row"},        ref_row, 0);
    checkOutput({tag, "_ref_row_valid"},  ref_row_valid, 0);
    checkOutput({tag, "_stat_curr"},      stat_curr_cnt, 0);
    checkOutput({tag, "_stat_ref"},       stat_ref_cnt, 0);
  endtask

  // Monitor: every strobe or valid the DUT shows must match the head of its queue.
  rd_exp_t  mr;
  row_exp_t mw;
  always @(negedge clk) begin
    if (curr_rd_en) begin
      if (curr_rd_q.size() == 0) checkOutput("curr_rd_unexpected", curr_rd_en, 0);
      else begin
        mr = curr_rd_q.pop_front();
        checkOutput("curr_rd_addr", curr_rd_addr, mr.addr[5:0]);
        checkOutput("curr_rd_cycle", cyc, mr.cyc);
      end
    end else if (curr_rd_q.size() != 0 && curr_rd_q[0].cyc < cyc) begin
      mr = curr_rd_q.pop_front();
      checkOutput("curr_rd_missing", curr_rd_en, 1);
    end

    if (ref_rd_en) begin
      if (ref_rd_q.size() == 0) checkOutput("ref_rd_unexpected", ref_rd_en, 0);
      else begin
        mr = ref_rd_q.pop_front();
        checkOutput("ref_rd_addr", ref_rd_addr, mr.addr);
        checkOutput("ref_rd_cycle", cyc, mr.cyc);
      end
    end else if (ref_rd_q.size() != 0 && ref_rd_q[0].cyc < cyc) begin
      mr = ref_rd_q.pop_front();
      checkOutput("ref_rd_missing", ref_rd_en, 1);
    end

    if (curr_row_valid) begin
      if (curr_row_q.size() == 0) checkOutput("curr_row_unexpected", curr_row_valid, 0);
      else begin
        mw = curr_row_q.pop_front();
        checkOutput("curr_row_data", curr_row, mw.data);
        checkOutput("curr_row_cb", curr_row_cb, mw.cb);
        checkOutput("curr_row_idx", curr_row_idx, mw.idx);
        checkOutput("curr_row_cycle", cyc, mw.cyc);
      end
    end else if (curr_row_q.size() != 0 && curr_row_q[0].cyc < cyc) begin
      mw = curr_row_q.pop_front();
      checkOutput("curr_row_missing", curr_row_valid, 1);
    end

    if (ref_row_valid) begin
      if (ref_row_q.size() == 0) checkOutput("ref_row_unexpected", ref_row_valid, 0);
      else begin
        mw = ref_row_q.pop_front();
        checkOutput("ref_row_data", ref_row, mw.data);
        checkOutput("ref_row_cycle", cyc, mw.cyc);
      end
    end else if (ref_row_q.size() != 0 && ref_row_q[0].cyc < cyc) begin
      mw = ref_row_q.pop_front();
      checkOutput("ref_row_missing", ref_row_valid, 1);
    end
  end

  initial begin
    logic [15:0] exp_sc, exp_sr;
    rst_n               = 1'b0;
    in_curr_enable      = 1'b0;
    CB_select           = 1'b0;
    change_ref          = 1'b0;
    ref_input_control   = 1'b0;
    search_column_count = 5'd0;
    search_row_count    = 7'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] burst CB_select=1, 32 rows");
    for (int i = 0; i < 32; i++) applyStimulus(1, 1, 0, 0, 5'd0, 7'd0, 1, 6'(i), 0, 12'd0);

    $display("[TB] burst CB_select=0, 38 cycles, only 32 reads");
    for (int i = 0; i < 38; i++) begin
      if (i < 32) applyStimulus(1, 0, 0, 0, 5'd0, 7'd0, 1, 6'(32 + i), 0, 12'd0);
      else        applyStimulus(1, 0, 0, 0, 5'd0, 7'd0, 0, 6'd0, 0, 12'd0);
    end

    $display("[TB] reference rows, column 5");
    applyStimulus(0, 0, 1, 1, 5'd5, 7'd0, 0, 6'd0, 1, 12'h280);
    applyStimulus(0, 0, 1, 1, 5'd5, 7'd1, 0, 6'd0, 1, 12'h281);
    applyStimulus(0, 0, 1, 0, 5'd5, 7'd2, 0, 6'd0, 0, 12'd0);
    applyStimulus(0, 0, 1, 1, 5'd5, 7'd2, 0, 6'd0, 1, 12'h282);
    applyStimulus(0, 0, 1, 1, 5'd5, 7'd0, 0, 6'd0, 1, 12'h280);
    applyStimulus(0, 0, 1, 1, 5'd5, 7'd3, 0, 6'd0, 1, 12'h281);

    $display("[TB] simultaneous current and reference request");
    applyStimulus(1, 1, 1, 1, 5'd3, 7'd0, 1, 6'd0, 1, 12'h180);

    $display("[TB] idle timeout boundary");
    idleCycles(63);
    applyStimulus(0, 0, 1, 1, 5'd7, 7'd0, 0, 6'd0, 1, 12'h380);
    idleCycles(64);
    applyStimulus(0, 0, 1, 1, 5'd7, 7'd0, 0, 6'd0, 0, 12'd0);
    @(negedge clk);
    checkOutput("idle_ref_ignored", ref_rd_en, 0);
    @(posedge clk);
    #1;
    idleCycles(6);

    checkOutput("curr_rows_drained", curr_row_q.size(), 0);
    checkOutput("ref_rows_drained", ref_row_q.size(), 0);
`ifdef ME_FEEDER_STATS_EN
    exp_sc = 16'(n_curr);
    exp_sr = 16'(n_ref);
`else
    exp_sc = 16'd0;
    exp_sr = 16'd0;
`endif
    checkOutput("stat_curr_cnt", stat_curr_cnt, exp_sc);
    checkOutput("stat_ref_cnt", stat_ref_cnt, exp_sr);

    $display("[TB] reset in the middle of a burst");
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 5'd0, 7'd0, 1, 6'(32 + i), 0, 12'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    curr_rd_q.delete();
    ref_rd_q.delete();
    curr_row_q.delete();
    ref_row_q.delete();
    @(negedge clk);
    checkResetState("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idleCycles(8);

    $display("%0d/%0d checks passed", n_check - n_fail, n_check);
    $finish;
  end

endmodule
